rr_mux_param: RTL and testbench
===============================

// Module: rr_mux_param
// PURPOSE
//  Registered, round-robin arbitrated SIZE:1 mux with per-channel valid/ready handshake.
//  Successor to the plain select-driven parametrised mux: the select is generated internally
//  and fair, and multi-beat packets are optionally held atomic (grant lock).
//  The output is registered and carries the winning channel index.
//  Used where several wavefront/issue sources share one downstream port (e.g. LSU or SALU request bus).
// PARAMETERS
//  SIZE     4   number of input channels (>=2, need not be a power of two)
//  BITS     2   width of channel index; must satisfy 2**BITS >= SIZE
//  WIDTH   32   data bits per channel
//  LOCK_EN  1   1: hold grant from first beat to in_last beat; 0: arbitrate every beat
// PORTS
//  clk        in   1           clock, all state on rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  in_data    in   SIZE*WIDTH  channel i occupies [WIDTH*(i+1)-1 -: WIDTH]
//  in_valid   in   SIZE        channel i has a beat
//  in_last    in   SIZE        beat on channel i ends its packet
//  in_ready   out  SIZE        beat on channel i accepted this cycle (one-hot or zero)
//  out_data   out  WIDTH       registered winning beat
//  out_sel    out  BITS        index of channel that produced out_data
//  out_last   out  1           registered in_last of winning beat
//  out_valid  out  1           out_data/out_sel/out_last valid
//  out_ready  in   1           downstream accepts when out_valid && out_ready
// BEHAVIOUR
//  Reset (async assert, sync deassert by the system): out_valid=0, out_data=0, out_sel=0,
//   out_last=0, ptr=0, locked=0, lock_ch=0; in_ready=0 while rst_n=0.
//  space = !out_valid || out_ready (output register free or emptying this cycle).
//  Candidate g: if locked, g=lock_ch (only if in_valid[lock_ch]); else first i with in_valid[i]
//   searching ptr, ptr+1, ... wrapping mod SIZE (not mod 2**BITS).
//  Accept: any candidate && space -> in_ready[g]=1 (combinational), and the register loads
//   data/sel/last of g next edge, out_valid<=1. Otherwise in_ready=0 everywhere.
//  No accept && out_valid && out_ready -> out_valid<=0; other output regs hold value.
//  No accept && out_valid && !out_ready -> all output regs hold (stable while stalled).
//  Latency 1 cycle in->out; full throughput (1 beat/cycle) with out_ready held high.
//  Lock (LOCK_EN=1): accept with in_last[g]=0 -> locked<=1, lock_ch<=g;
//   accept with in_last[g]=1 -> locked<=0. When locked and lock_ch is not valid, no grant
//   (other channels wait; no bubble-filling).
//  LOCK_EN=0: locked is always 0; in_last is only passed through.
//  Pointer: on accept that ends arbitration (in_last=1, or LOCK_EN=0), ptr<=(g==SIZE-1)?0:g+1.
//   Mid-packet beats do not move ptr.
//  in_valid asserted with in_ready=0: source must hold data; block does not require it but
//   fairness is only guaranteed to sources that hold valid.
//  Starvation bound: a held-valid channel is granted within SIZE-1 packets of others.
//  Reset mid-packet: pending output beat is discarded, lock cleared, ptr=0.
//  out_ready with out_valid=0 is ignored.
// STRUCTURE
//  Shared include (common defines): clog2 helper function used to check BITS vs SIZE.
//  Sub-module rr_pick: combinational rotated priority encoder
//   (in: req[SIZE], ptr[BITS]; out: gnt_idx[BITS], gnt_any). Top holds ptr, lock and output regs.
//  No other hierarchy; input slicing uses the same indexed part-select layout as mux_param.
// TESTING
//  1 Reset: rst_n=0 with all in_valid=1 -> out_valid=0, in_ready=0000, out_sel=0.
//  2 Fairness: SIZE=4, LOCK_EN=0, all valid, last=1, out_ready=1 -> out_sel 0,1,2,3,0 on
//    consecutive cycles after 1-cycle latency.
//  3 Lock: ch2 sends 3 beats (last on 3rd), ch0 valid throughout -> out_sel=2,2,2 then 0;
//    in_ready[0]=0 during the packet.
//  4 Back-pressure: out_valid=1, out_ready=0 for 5 cycles -> in_ready=0000, out_data stable;
//    out_ready=1 -> next beat accepted same cycle, no beat lost or duplicated.
//  5 Wrap with SIZE=3, BITS=2: ptr after granting ch2 is 0 (never 3); ch0/ch2 valid ->
//    alternate 2,0,2,0.
//  6 Async reset mid-packet (locked on ch1) -> out_valid=0 immediately, then ch0 wins first.

Source files
------------

// File: rtl/rr_mux_param_pkg.sv
// Shared types and helpers for the round-robin arbitrated mux.
package rr_mux_param_pkg;

    // Arbitration state: free to pick any channel, or held on one channel
    // until the current packet's last beat.
    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // Number of bits needed to index n items (n >= 1); used to validate BITS.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_mux_param_pick.sv
// Combinational rotated priority encoder: the first requester found when
// scanning from ptr upward, wrapping at SIZE (not at 2**BITS), wins.
module rr_pick
    import rr_mux_param_pkg::*;
#(
    parameter int SIZE = 4,
    parameter int BITS = 2
) (
    input  logic [SIZE-1:0] req,
    input  logic [BITS-1:0] ptr,
    output logic [BITS-1:0] gnt_idx,
    output logic            gnt_any
);

    int              w_idx;
    logic [BITS-1:0] w_pos;

    // Scan SIZE positions starting at ptr; ptr is always < SIZE so one
    // subtraction is enough to wrap.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        w_idx   = 0;
        w_pos   = '0;
        for (int k = 0; k < SIZE; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= SIZE) w_idx = w_idx - SIZE;
            w_pos = BITS'(w_idx);
            if (!gnt_any && req[w_pos]) begin
                gnt_any = 1'b1;
                gnt_idx = w_pos;
            end
        end
    end

endmodule

// File: rtl/rr_mux_param.sv
// Registered SIZE:1 round-robin mux with valid/ready on every channel and an
// optional grant lock that keeps multi-beat packets contiguous on the output.
module rr_mux_param
    import rr_mux_param_pkg::*;
#(
    parameter int SIZE    = 4,
    parameter int BITS    = 2,
    parameter int WIDTH   = 32,
    parameter bit LOCK_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SIZE*WIDTH-1:0] in_data,
    input  logic [SIZE-1:0]       in_valid,
    input  logic [SIZE-1:0]       in_last,
    output logic [SIZE-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [BITS-1:0]       out_sel,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [BITS-1:0] LAST_CH = BITS'(SIZE - 1);

    // The index must be able to address every channel.
    if (SIZE < 2 || clog2(SIZE) > BITS) begin : g_bad_bits
        $error("rr_mux_param: BITS=%0d too small for SIZE=%0d", BITS, SIZE);
    end

    logic [WIDTH-1:0] w_ch_data [SIZE];

    for (genvar i = 0; i < SIZE; i++) begin : g_slice
        assign w_ch_data[i] = in_data[WIDTH*(i+1)-1 -: WIDTH];
    end

    arb_state_e      r_state, w_state_nxt;
    logic [BITS-1:0] r_ptr, w_ptr_nxt;
    logic [BITS-1:0] r_lock_ch, w_lock_ch_nxt;

    logic [WIDTH-1:0] r_out_data;
    logic [BITS-1:0]  r_out_sel;
    logic             r_out_last;
    logic             r_out_valid;

    logic [SIZE-1:0] w_lock_mask;
    logic [SIZE-1:0] w_req;
    logic [BITS-1:0] w_gnt;
    logic            w_any;
    logic            w_space;
    logic            w_acc;
    logic            w_locked;

    assign w_locked = (r_state == ST_LOCK);
    assign w_space  = !r_out_valid || out_ready;
    // Never accept while reset is held, even though the output is empty.
    assign w_acc    = w_any && w_space && rst_n;

    // While locked only the owning channel may request; others simply wait.
    always_comb begin
        w_lock_mask = '0;
        for (int i = 0; i < SIZE; i++) begin
            w_lock_mask[i] = (r_lock_ch == BITS'(i));
        end
        w_req = w_locked ? (in_valid & w_lock_mask) : in_valid;
    end

    rr_pick #(
        .SIZE (SIZE),
        .BITS (BITS)
    ) u_pick (
        .req     (w_req),
        .ptr     (r_ptr),
        .gnt_idx (w_gnt),
        .gnt_any (w_any)
    );

    // One-hot ready to the winner only on a cycle the beat is taken.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < SIZE; i++) begin
            in_ready[i] = w_acc && (w_gnt == BITS'(i));
        end
    end

    // Lock / pointer next state: a packet end (or every beat with no lock)
    // frees arbitration and moves the pointer past the winner.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_lock_ch_nxt = r_lock_ch;
        if (w_acc) begin
            if (in_last[w_gnt] || !LOCK_EN) begin
                w_state_nxt = ST_ARB;
                w_ptr_nxt   = (w_gnt == LAST_CH) ? '0 : w_gnt + BITS'(1);
            end else begin
                w_state_nxt   = ST_LOCK;
                w_lock_ch_nxt = w_gnt;
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_ARB;
            r_ptr     <= '0;
            r_lock_ch <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_lock_ch <= w_lock_ch_nxt;
        end
    end

    // Output register: load on accept, drain when consumed, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_acc) begin
            r_out_data  <= w_ch_data[w_gnt];
            r_out_sel   <= w_gnt;
            r_out_last  <= in_last[w_gnt];
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux_param.sv
// Directed bench for rr_mux_param: three instances (4 ch no lock, 4 ch lock,
// 3 ch lock) driven by a vector table plus hand-written sequences.
module tb_rr_mux_param;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // 4 channels, LOCK_EN=0
    logic [4*W-1:0] nl_data;
    logic [3:0]     nl_valid, nl_last, nl_ird;
    logic [W-1:0]   nl_odata;
    logic [1:0]     nl_osel;
    logic           nl_olast, nl_ovalid, nl_ordy;

    // 4 channels, LOCK_EN=1
    logic [4*W-1:0] lk_data;
    logic [3:0]     lk_valid, lk_last, lk_ird;
    logic [W-1:0]   lk_odata;
    logic [1:0]     lk_osel;
    logic           lk_olast, lk_ovalid, lk_ordy;

    // 3 channels, BITS=2, LOCK_EN=1
    logic [3*W-1:0] s3_data;
    logic [2:0]     s3_valid, s3_last, s3_ird;
    logic [W-1:0]   s3_odata;
    logic [1:0]     s3_osel;
    logic           s3_olast, s3_ovalid, s3_ordy;

    rr_mux_param #(.SIZE(4), .BITS(2), .WIDTH(W), .LOCK_EN(1'b0)) u_nl (
        .clk(clk), .rst_n(rst_n), .in_data(nl_data), .in_valid(nl_valid),
        .in_last(nl_last), .in_ready(nl_ird), .out_data(nl_odata), .out_sel(nl_osel),
        .out_last(nl_olast), .out_valid(nl_ovalid), .out_ready(nl_ordy));

    rr_mux_param #(.SIZE(4), .BITS(2), .WIDTH(W), .LOCK_EN(1'b1)) u_lk (
        .clk(clk), .rst_n(rst_n), .in_data(lk_data), .in_valid(lk_valid),
        .in_last(lk_last), .in_ready(lk_ird), .out_data(lk_odata), .out_sel(lk_osel),
        .out_last(lk_olast), .out_valid(lk_ovalid), .out_ready(lk_ordy));

    rr_mux_param #(.SIZE(3), .BITS(2), .WIDTH(W), .LOCK_EN(1'b1)) u_s3 (
        .clk(clk), .rst_n(rst_n), .in_data(s3_data), .in_valid(s3_valid),
        .in_last(s3_last), .in_ready(s3_ird), .out_data(s3_odata), .out_sel(s3_osel),
        .out_last(s3_olast), .out_valid(s3_ovalid), .out_ready(s3_ordy));

    typedef struct packed {
        logic [3:0] v;
        logic [3:0] l;
        logic       ordy;
        logic [3:0] erdy;
        logic       ev;
        logic [1:0] esel;
        logic       el;
    } vec_t;

    vec_t tab [10];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic logic [4*W-1:0] mk4(input logic [W-1:0] d0, d1, d2, d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic lk_step(input string nm, input logic [3:0] v, l, input logic r,
                           input logic [4*W-1:0] d, input logic [3:0] erdy, input logic ev,
                           input logic [1:0] esel, input logic el, input logic [W-1:0] ed);
        @(negedge clk);
        lk_valid = v; lk_last = l; lk_ordy = r; lk_data = d;
        #1 chk({nm, ".in_ready"}, W'(lk_ird), W'(erdy));
        @(posedge clk); #1;
        chk({nm, ".out_valid"}, W'(lk_ovalid), W'(ev));
        chk({nm, ".out_sel"},   W'(lk_osel),   W'(esel));
        chk({nm, ".out_last"},  W'(lk_olast),  W'(el));
        chk({nm, ".out_data"},  lk_odata,      ed);
    endtask

    task automatic s3_step(input string nm, input logic [2:0] v, l,
                           input logic [2:0] erdy, input logic ev,
                           input logic [1:0] esel, input logic el);
        @(negedge clk);
        s3_valid = v; s3_last = l; s3_ordy = 1'b1;
        #1 chk({nm, ".in_ready"}, W'(s3_ird), W'(erdy));
        @(posedge clk); #1;
        chk({nm, ".out_valid"}, W'(s3_ovalid), W'(ev));
        chk({nm, ".out_sel"},   W'(s3_osel),   W'(esel));
        chk({nm, ".out_last"},  W'(s3_olast),  W'(el));
        chk({nm, ".out_data"},  s3_odata,      32'h3000_0000 | W'(esel));
    endtask

    initial begin
        //            v        l        r     erdy     ev    sel   last
        tab[0] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
        tab[1] = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1};
        tab[2] = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
        tab[3] = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
        tab[4] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
        tab[5] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1};
        tab[6] = '{4'b1100, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0};
        tab[7] = '{4'b0011, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
        tab[8] = '{4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b1};
        tab[9] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};

        nl_data  = mk4(32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003);
        s3_data  = {32'h3000_0002, 32'h3000_0001, 32'h3000_0000};
        lk_data  = '0;
        nl_valid = 4'b1111; nl_last = 4'b1111; nl_ordy = 1'b1;
        lk_valid = 4'b1111; lk_last = 4'b1111; lk_ordy = 1'b1;
        s3_valid = 3'b111;  s3_last = 3'b111;  s3_ordy = 1'b1;

        // Reset held with every channel valid: nothing accepted, outputs cleared.
        @(posedge clk); @(posedge clk); #1;
        chk("rst.nl_in_ready", W'(nl_ird), '0);
        chk("rst.nl_out_valid", W'(nl_ovalid), '0);
        chk("rst.nl_out_sel", W'(nl_osel), '0);
        chk("rst.lk_in_ready", W'(lk_ird), '0);
        chk("rst.lk_out_valid", W'(lk_ovalid), '0);
        chk("rst.s3_in_ready", W'(s3_ird), '0);
        chk("rst.s3_out_valid", W'(s3_ovalid), '0);
        @(negedge clk);
        rst_n = 1'b1;
        lk_valid = '0; s3_valid = '0; nl_valid = '0;

        // Fairness / pass-through table on the unlocked instance.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nl_valid = tab[i].v; nl_last = tab[i].l; nl_ordy = tab[i].ordy;
            #1 chk($sformatf("tab%0d.in_ready", i), W'(nl_ird), W'(tab[i].erdy));
            @(posedge clk); #1;
            chk($sformatf("tab%0d.out_valid", i), W'(nl_ovalid), W'(tab[i].ev));
            chk($sformatf("tab%0d.out_sel", i),   W'(nl_osel),   W'(tab[i].esel));
            chk($sformatf("tab%0d.out_last", i),  W'(nl_olast),  W'(tab[i].el));
            chk($sformatf("tab%0d.out_data", i),  nl_odata, 32'hD000_0000 | W'(tab[i].esel));
        end
        nl_valid = '0;

        // Lock: ch2 three-beat packet, ch0 waiting; ch2 gap stalls grant.
        lk_step("lock.b1", 4'b0100, 4'b0000, 1'b1, mk4(32'hAA, 0, 32'h2000_0001, 0),
                4'b0100, 1'b1, 2'd2, 1'b0, 32'h2000_0001);
        lk_step("lock.b2", 4'b0101, 4'b0000, 1'b1, mk4(32'hAA, 0, 32'h2000_0002, 0),
                4'b0100, 1'b1, 2'd2, 1'b0, 32'h2000_0002);
        lk_step("lock.gap", 4'b0001, 4'b0000, 1'b1, mk4(32'hAA, 0, 32'h2000_0002, 0),
                4'b0000, 1'b0, 2'd2, 1'b0, 32'h2000_0002);
        lk_step("lock.b3", 4'b0101, 4'b0100, 1'b1, mk4(32'hAA, 0, 32'h2000_0003, 0),
                4'b0100, 1'b1, 2'd2, 1'b1, 32'h2000_0003);
        lk_step("lock.ch0", 4'b0001, 4'b0001, 1'b1, mk4(32'hAA, 0, 0, 0),
                4'b0001, 1'b1, 2'd0, 1'b1, 32'hAA);

        // Back-pressure: output held stable, then next beat taken exactly once.
        lk_step("bp.load", 4'b0010, 4'b0010, 1'b1, mk4(0, 32'h1111_0001, 0, 0),
                4'b0010, 1'b1, 2'd1, 1'b1, 32'h1111_0001);
        for (int i = 0; i < 5; i++) begin
            lk_step($sformatf("bp.stall%0d", i), 4'b0010, 4'b0010, 1'b0,
                    mk4(0, 32'h1111_0002, 0, 0), 4'b0000, 1'b1, 2'd1, 1'b1, 32'h1111_0001);
        end
        lk_step("bp.release", 4'b0010, 4'b0010, 1'b1, mk4(0, 32'h1111_0002, 0, 0),
                4'b0010, 1'b1, 2'd1, 1'b1, 32'h1111_0002);
        lk_step("bp.drain", 4'b0000, 4'b0000, 1'b1, mk4(0, 32'h1111_0002, 0, 0),
                4'b0000, 1'b0, 2'd1, 1'b1, 32'h1111_0002);

        // SIZE=3 wrap: after ch2 the pointer returns to 0.
        s3_step("s3.a", 3'b100, 3'b111, 3'b100, 1'b1, 2'd2, 1'b1);
        s3_step("s3.b", 3'b101, 3'b111, 3'b001, 1'b1, 2'd0, 1'b1);
        s3_step("s3.c", 3'b101, 3'b111, 3'b100, 1'b1, 2'd2, 1'b1);
        s3_step("s3.d", 3'b101, 3'b111, 3'b001, 1'b1, 2'd0, 1'b1);
        s3_step("s3.e", 3'b101, 3'b111, 3'b100, 1'b1, 2'd2, 1'b1);
        s3_step("s3.f", 3'b011, 3'b111, 3'b001, 1'b1, 2'd0, 1'b1);
        s3_step("s3.lk", 3'b001, 3'b000, 3'b001, 1'b1, 2'd0, 1'b0);
        s3_step("s3.wait", 3'b110, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0);
        s3_step("s3.end", 3'b111, 3'b001, 3'b001, 1'b1, 2'd0, 1'b1);
        s3_step("s3.next", 3'b110, 3'b111, 3'b010, 1'b1, 2'd1, 1'b1);
        s3_valid = '0;

        // Async reset while locked on ch1.
        lk_step("mid.lock", 4'b0010, 4'b0000, 1'b1, mk4(0, 32'h1111_0003, 0, 0),
                4'b0010, 1'b1, 2'd1, 1'b0, 32'h1111_0003);
        #2;
        rst_n = 1'b0;
        lk_valid = 4'b1111;
        #1;
        chk("mid.rst_out_valid", W'(lk_ovalid), '0);
        chk("mid.rst_in_ready", W'(lk_ird), '0);
        chk("mid.rst_out_sel", W'(lk_osel), '0);
        chk("mid.rst_out_data", lk_odata, '0);
        @(negedge clk);
        rst_n = 1'b1;
        lk_valid = '0;
        lk_step("mid.after", 4'b0011, 4'b0011, 1'b1, mk4(32'h0A, 32'h0B, 0, 0),
                4'b0001, 1'b1, 2'd0, 1'b1, 32'h0A);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
